rr_arb_8_enc: RTL and testbench
===============================

RR_ARB_8_ENC -- requirements
Module: rr_arb_8_enc

Interface
REQ-001 Parameter: PTR_INIT, default 3'd0, the search start index loaded into the priority pointer at reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low; all state is cleared immediately when it goes low.
REQ-004 Port: en  input  1  arbitration enable; low blocks new grants but does not drop a held grant.
REQ-005 Port: req  input  8  request vector; bit i means requester i wants service.
REQ-006 Port: gnt_idx  output  3  binary index of the granted requester; it feeds the downstream 3-to-8 decoder.
REQ-007 Port: gnt_valid  output  1  gnt_idx holds a live grant.
REQ-008 Port: gnt_ready  input  1  downstream accepts the grant this cycle.
REQ-009 Port: busy  output  1  high whenever the FSM is in GRANT.

Function
REQ-010 The block SHALL implement a two-state FSM with states IDLE and GRANT, and SHALL drive all outputs from registers.
REQ-011 Handshake: a grant SHALL be accepted on any rising edge where gnt_valid=1 and gnt_ready=1.
REQ-012 Search rule: the candidate SHALL be the first set bit of req, scanning indices ptr, ptr+1, ... modulo 8.
REQ-013 The search SHALL be evaluated only when en=1 and the block is either in IDLE or accepting a grant in the current cycle.
REQ-014 IDLE -> GRANT: if the search finds a candidate, then on the next edge gnt_idx SHALL take the candidate value and gnt_valid SHALL be 1, giving 1-cycle latency from req to grant.
REQ-015 IDLE with en=0 or req=8'h00 SHALL stay in IDLE with gnt_valid=0.
REQ-016 GRANT without acceptance: gnt_idx and gnt_valid SHALL hold stable regardless of changes on req or en.
REQ-017 A withdrawn request SHALL NOT revoke a grant that is already held.
REQ-018 On acceptance, ptr SHALL load gnt_idx+1 modulo 8, so index 7 wraps to 0.
REQ-019 On acceptance, the same-cycle search SHALL use the updated ptr (gnt_idx+1).
REQ-020 On acceptance with a candidate found, the FSM SHALL stay in GRANT with the new gnt_idx, sustaining one grant per cycle back-to-back.
REQ-021 On acceptance with no candidate, or with en=0, the FSM SHALL go to IDLE with gnt_valid=0 and gnt_idx holding its last value.
REQ-022 The pointer SHALL change only on acceptance; an unaccepted grant SHALL NOT advance it.
REQ-023 Fairness: with all 8 bits of req held high and gnt_ready=1, grants SHALL cycle through 0..7 in order with no repeat within any 8 consecutive grants.
REQ-024 gnt_ready while gnt_valid=0 SHALL have no effect.
REQ-025 busy SHALL equal (state==GRANT) and SHALL always match gnt_valid.

Reset
REQ-026 While rst_n=0: state=IDLE, gnt_valid=0, gnt_idx=3'd0, busy=0, ptr=PTR_INIT, all taking effect without a clock edge.
REQ-027 If reset is asserted during GRANT, the pending grant SHALL be discarded and never reported as accepted.
REQ-028 On the first rising edge after rst_n deasserts, the block SHALL start from IDLE and may issue a grant if req is nonzero and en=1.

Verification
REQ-029 Reset check: assert rst_n=0 mid-cycle while gnt_valid=1 -> gnt_valid=0 and gnt_idx=0 immediately; after release with req=8'h04, en=1 -> gnt_idx=2, gnt_valid=1 one cycle later.
REQ-030 Round robin: req=8'hFF, en=1, gnt_ready=1 for 10 cycles -> gnt_idx sequence 0,1,2,3,4,5,6,7,0,1 with gnt_valid held at 1.
REQ-031 Backpressure: req=8'h22, gnt_ready=0 for 4 cycles then 1 -> gnt_idx=1 held 5 cycles, then 5 on the next cycle, then 1 again.
REQ-032 Withdrawal and wrap: grant on idx 7 held with gnt_ready=0, req driven to 8'h00 -> grant still 7; then gnt_ready=1 with req=8'h01 -> next grant 0 (ptr wrapped), then IDLE once req=0.
REQ-033 Enable gating: en=0 with req=8'h10 -> gnt_valid stays 0; en=1 -> gnt_idx=4 the next cycle; en=0 during a held grant -> grant holds until accepted, then IDLE.
REQ-034 Decoder chain: feed gnt_idx into the 3-to-8 decoder with req=8'h81 and gnt_ready=1 -> decoder output alternates 8'b00000001 and 8'b10000000 on every cycle.

Source files
------------

// File: rtl/rr_arb_8_enc.sv
// rr_arb_8_enc -- 8-way round-robin arbiter with a binary-encoded grant.
//
// The search for the next requester starts at an internal priority pointer.
// The pointer moves to (granted index + 1) only when a grant is accepted.
// A held grant stays stable until it is accepted, whatever happens on req or en.
// An accepting cycle can issue the next grant at once, so the arbiter can
// sustain one grant per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         arbitration enable (blocks new grants, never drops a held one)
//   req[7:0]   request vector, bit i = requester i wants service
//   gnt_idx    binary index of the granted requester (feeds a 3-to-8 decoder)
//   gnt_valid  gnt_idx holds a live grant
//   gnt_ready  downstream accepts the grant this cycle
//   busy       FSM is in GRANT (always equal to gnt_valid)
module rr_arb_8_enc #(
  parameter logic [2:0] PTR_INIT = 3'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  input  logic       gnt_ready,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [2:0] idx_q, idx_n;

  logic       accept;
  logic       search_en;
  logic [2:0] search_ptr;
  logic       found;
  logic [2:0] cand;
  logic [2:0] probe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= PTR_INIT;
      idx_q <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      idx_q <= idx_n;
    end
  end

  // On an accepting cycle the search already uses the advanced pointer, so
  // back-to-back grants see the same priority order as a fresh search.
  always_comb begin
    accept     = (state == GRANT) && gnt_ready;
    search_ptr = accept ? (idx_q + 3'd1) : ptr;
    search_en  = en && ((state == IDLE) || accept);

    found = 1'b0;
    cand  = '0;
    probe = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      probe = search_ptr + 3'(i);
      if (!found && req[probe]) begin
        found = 1'b1;
        cand  = probe;
      end
    end

    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx_q;

    case (state)
      IDLE: begin
        if (search_en && found) begin
          state_n = GRANT;
          idx_n   = cand;
        end
      end
      GRANT: begin
        if (accept) begin
          ptr_n = search_ptr;
          if (search_en && found) begin
            idx_n = cand;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign gnt_idx   = idx_q;
  assign gnt_valid = (state == GRANT);
  assign busy      = (state == GRANT);

endmodule

// File: tb/tb_rr_arb_8_enc.sv
module tb_rr_arb_8_enc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic       gnt_ready = 1'b0;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       busy;
  logic [7:0] dec;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: a grant slot and the next search start.
  int  m_idx;
  int  m_ptr;
  bit  m_valid;

  rr_arb_8_enc #(.PTR_INIT(3'd0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Downstream 3-to-8 decoder fed by the encoded grant.
  assign dec = 8'(1) << gnt_idx;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock of the reference: a held, unaccepted grant is frozen;
  // otherwise the grant slot is refilled by a circular scan of req.
  task automatic model_edge();
    bit acc;
    bit hit;
    acc = m_valid && gnt_ready;
    if (acc) m_ptr = (m_idx + 1) % 8;
    if (m_valid && !acc) return;
    hit = 1'b0;
    if (en) begin
      for (int k = 0; k < 8; k++) begin
        if (!hit && req[(m_ptr + k) % 8]) begin
          hit   = 1'b1;
          m_idx = (m_ptr + k) % 8;
        end
      end
    end
    m_valid = hit;
  endtask

  task automatic step_chk();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("valid", 32'(gnt_valid), 32'(m_valid));
    chk("idx",   32'(gnt_idx),   32'(m_idx));
    chk("busy",  32'(busy),      32'(m_valid));
  endtask

  // Called right after a negedge: reset asserted mid-cycle, checked before
  // any clock edge, released on the following negedge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    #1;
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    chk("rst_idx",   32'(gnt_idx),   32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Round robin over a full request vector.
    req = 8'hFF; en = 1'b1; gnt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_chk();
      chk("rr_seq", 32'(gnt_idx), 32'(i % 8));
      chk("rr_valid", 32'(gnt_valid), 32'd1);
    end
    req = 8'h00;
    step_chk();
    chk("rr_idle", 32'(gnt_valid), 32'd0);

    // Backpressure holds the grant and freezes the pointer.
    do_reset();
    req = 8'h22; en = 1'b1; gnt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step_chk();
      chk("bp_hold", 32'(gnt_idx), 32'd1);
    end
    gnt_ready = 1'b1;
    step_chk();
    chk("bp_next", 32'(gnt_idx), 32'd5);
    step_chk();
    chk("bp_wrap", 32'(gnt_idx), 32'd1);

    // Withdrawal does not revoke, pointer wraps from 7 to 0.
    do_reset();
    req = 8'h80; en = 1'b1; gnt_ready = 1'b0;
    step_chk();
    chk("wd_grant", 32'(gnt_idx), 32'd7);
    req = 8'h00;
    step_chk();
    chk("wd_hold", 32'(gnt_idx), 32'd7);
    chk("wd_holdv", 32'(gnt_valid), 32'd1);
    gnt_ready = 1'b1; req = 8'h01;
    step_chk();
    chk("wd_wrap", 32'(gnt_idx), 32'd0);
    req = 8'h00;
    step_chk();
    chk("wd_idle", 32'(gnt_valid), 32'd0);

    // Enable gating.
    do_reset();
    en = 1'b0; req = 8'h10; gnt_ready = 1'b1;
    step_chk();
    chk("en_block", 32'(gnt_valid), 32'd0);
    en = 1'b1;
    step_chk();
    chk("en_grant", 32'(gnt_idx), 32'd4);
    en = 1'b0; gnt_ready = 1'b0;
    step_chk();
    chk("en_hold", 32'(gnt_valid), 32'd1);
    gnt_ready = 1'b1;
    step_chk();
    chk("en_idle", 32'(gnt_valid), 32'd0);
    chk("en_lastidx", 32'(gnt_idx), 32'd4);

    // Decoder chain alternates between the two live requesters.
    do_reset();
    req = 8'h81; en = 1'b1; gnt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_chk();
      chk("dec", 32'(dec), (i % 2 == 0) ? 32'h01 : 32'h80);
    end

    // Reset during a live grant, then a fresh grant one cycle after release.
    chk("pre_rst_valid", 32'(gnt_valid), 32'd1);
    req = 8'h04; en = 1'b1; gnt_ready = 1'b0;
    do_reset();
    step_chk();
    chk("post_rst_idx", 32'(gnt_idx), 32'd2);
    chk("post_rst_valid", 32'(gnt_valid), 32'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: req = 8'h00;
        1: req = 8'(1) << $urandom_range(0, 7);
        default: req = 8'($urandom);
      endcase
      en        = ($urandom_range(0, 7) != 0);
      gnt_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 63) == 0) do_reset();
      else step_chk();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
